uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
UART receive-side core, the counterpart of the TX serializer path. It oversamples the serial line RX_IN at Prescale clocks per bit and detects the start bit. Each data bit is recovered by a 3-sample majority vote, LSB first. The block then checks optional parity and the stop bit, and presents the parallel word with a one-cycle Data_Valid pulse plus per-frame error flags to the host logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, LSB transmitted first.
PRESCALE_WIDTH, 6, width of the Prescale input.

Ports:
CLK  input  1  system clock, all logic on rising edge.
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high, asynchronous to CLK.
Prescale  input  PRESCALE_WIDTH  oversampling ratio (clocks per bit); supported values 8, 16, 32.
PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  received word, updated only on a valid frame.
Data_Valid  output  1  one-cycle pulse, P_DATA holds a new error-free word.
Par_Err  output  1  one-cycle pulse, parity mismatch in the completed frame.
Stop_Err  output  1  one-cycle pulse, sampled stop bit was 0.

Behaviour:
- Reset (RST low, async): FSM to IDLE; all counters 0; P_DATA=0; Data_Valid, Par_Err and Stop_Err = 0; synchronizer flops = 1.
- RX_IN passes through a 2-flop synchronizer (rx_s). All references below are to rx_s, which adds 2 cycles latency.
- Config latch: Prescale, PAR_EN and PAR_TYP are latched on IDLE->START. Changes mid-frame are ignored. Other Prescale values are unsupported and produce undefined output.
- Edge counter: counts 0..Prescale-1 within each bit, then wraps to 0 and increments the bit counter.
- Sample points: edge counts Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the 3 samples, resolved at edge count Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s=0 -> START, edge counter=0.
  - START: the resolved sample must be 0. If it resolves to 1 (glitch), return to IDLE with no flags. Otherwise, at edge Prescale-1 -> DATA.
  - DATA: shift the resolved bit into bit position DATA_WIDTH-1 of a shift register, shifting right. After DATA_WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: the expected bit is the XOR of the data bits for even parity, or its inverse for odd parity. At edge Prescale-1 -> STOP.
  - STOP: at stop-bit resolution (edge Prescale/2+2) evaluate the frame and go to IDLE immediately, half a bit early, so back-to-back frames tolerate clock mismatch.
- Frame evaluation, in the cycle after stop resolution:
  - Stop_Err = (stop sample==0).
  - Par_Err = PAR_EN && (parity mismatch).
  - If neither error: P_DATA <= shift register and Data_Valid=1 for exactly 1 cycle.
  - On any error: P_DATA holds its previous value and Data_Valid stays 0.
  - Par_Err and Stop_Err may both pulse together.
- Back-to-back frames: if rx_s=0 in IDLE right after STOP, the next START begins with no idle gap required.
- Latency: Data_Valid rises Prescale/2+3 CLK cycles after the stop bit starts on rx_s, i.e. +2 relative to RX_IN.
- Reset mid-frame: the frame is aborted immediately, with no pulses. After release the FSM waits in IDLE for a falling rx_s.
- Line held low (break): the frame ends with Stop_Err=1. The FSM then re-enters START and, if the line stays low, repeats Stop_Err each frame time. No hang.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 -> P_DATA=0xA5 and Data_Valid high exactly 1 cycle; Par_Err=Stop_Err=0.
2. Prescale=16, PAR_EN=1, PAR_TYP=0, byte 0x3C sent with parity bit 1 (wrong) -> Par_Err pulse, Data_Valid=0, P_DATA keeps its prior value.
3. Prescale=8, RX_IN low for 2 clocks, then high -> no state beyond START, no Data_Valid or errors, FSM back in IDLE.
4. Prescale=32, byte 0x81 with stop bit 0 -> Stop_Err pulse only, P_DATA unchanged; next good frame 0x7E -> Data_Valid with P_DATA=0x7E.
5. Prescale=16, PAR_EN=1, PAR_TYP=1, back-to-back 0x3C and 0xC3 with no idle gap, plus a 1-clock glitch inside one mid-bit sample window -> two Data_Valid pulses with 0x3C then 0xC3.
6. RST asserted during data bit 4 of a frame -> outputs at reset values immediately; the following full frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receive core: 2-flop sync, oversampled start detect, 3-sample majority per bit, parity and stop checks.
// Latency: Data_Valid / error flags pulse Prescale/2+3 cycles after the stop bit reaches rx_s.
// Backpressure: none. Results are single-cycle pulses, and host logic must capture them on the pulse.
//
// Ports:
//   CLK, RST                 - clock (rising edge), asynchronous active-low reset
//   RX_IN                    - asynchronous serial line, idle high
//   Prescale, PAR_EN, PAR_TYP - frame config, latched when a start bit is detected
//   P_DATA, Data_Valid       - received word and its one-cycle valid strobe
//   Par_Err, Stop_Err        - one-cycle per-frame error strobes
module uart_rx_deserializer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_Valid,
    output logic                      Par_Err,
    output logic                      Stop_Err
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] P1 = 1;
    localparam logic [PRESCALE_WIDTH-1:0] P2 = 2;
    localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state;
    logic                      rx_meta;
    logic                      rx_s;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [2:0]                samp;
    logic [DATA_WIDTH-1:0]     shift_reg;
    logic                      par_bit;
    logic [PRESCALE_WIDTH-1:0] ps_q;
    logic                      par_en_q;
    logic                      par_typ_q;

    logic [PRESCALE_WIDTH-1:0] half;
    logic                      at_s0, at_s1, at_s2, at_res, at_wrap;
    logic                      maj;
    logic                      par_err_c;

    // Sample/resolve points are relative to the config latched at frame start.
    assign half    = ps_q >> 1;
    assign at_s0   = (edge_cnt == half - P1);
    assign at_s1   = (edge_cnt == half);
    assign at_s2   = (edge_cnt == half + P1);
    assign at_res  = (edge_cnt == half + P2);
    assign at_wrap = (edge_cnt == ps_q - P1);

    assign maj       = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign par_err_c = par_en_q && (par_bit != ((^shift_reg) ^ par_typ_q));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shift_reg  <= '0;
            par_bit    <= 1'b0;
            ps_q       <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
        end else begin
            rx_meta    <= RX_IN;
            rx_s       <= rx_meta;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!rx_s) begin
                        state     <= START;
                        ps_q      <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                    end
                end
                default: begin
                    edge_cnt <= at_wrap ? '0 : edge_cnt + P1;
                    if (at_s0) samp[0] <= rx_s;
                    if (at_s1) samp[1] <= rx_s;
                    if (at_s2) samp[2] <= rx_s;

                    case (state)
                        START: begin
                            // A start bit that votes high was a line glitch.
                            if (at_res && maj)
                                state <= IDLE;
                            else if (at_wrap)
                                state <= DATA;
                        end
                        DATA: begin
                            if (at_res)
                                shift_reg <= {maj, shift_reg[DATA_WIDTH-1:1]};
                            if (at_wrap) begin
                                if (bit_cnt == LAST_BIT) begin
                                    bit_cnt <= '0;
                                    state   <= par_en_q ? PARITY : STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + BW'(1);
                                end
                            end
                        end
                        PARITY: begin
                            if (at_res)
                                par_bit <= maj;
                            if (at_wrap)
                                state <= STOP;
                        end
                        STOP: begin
                            // Leave mid-stop-bit so a following start edge is never missed.
                            if (at_res) begin
                                state    <= IDLE;
                                Stop_Err <= ~maj;
                                Par_Err  <= par_err_c;
                                if (maj && !par_err_c) begin
                                    Data_Valid <= 1'b1;
                                    P_DATA     <= shift_reg;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames checked against a frame-level model.
// Latency: model expects result pulses Prescale/2+6 cycles after the stop bit is driven onto RX_IN.
// Backpressure: none; every observed pulse is logged and matched in order against expected events.
module tb_uart_rx_deserializer;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       Par_Err;
    logic       Stop_Err;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .Par_Err    (Par_Err),
        .Stop_Err   (Stop_Err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int       cyc;
        bit       dv;
        bit       pe;
        bit       se;
        bit [7:0] d;
    } ev_t;

    ev_t      exp_q[$];
    ev_t      obs_q[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    bit [7:0] exp_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        ev_t o;
        if (Data_Valid || Par_Err || Stop_Err) begin
            o.cyc = cyc;
            o.dv  = Data_Valid;
            o.pe  = Par_Err;
            o.se  = Stop_Err;
            o.d   = P_DATA;
            obs_q.push_back(o);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Drives one bit for n cycles; cycle index gi (if in range) carries the inverted level.
    task automatic drive_bit(input bit b, input int n, input int gi);
        for (int j = 0; j < n; j++) begin
            RX_IN = (j == gi) ? ~b : b;
            @(posedge CLK);
            #1;
        end
    endtask

    // Sends a full frame and records the event the model predicts for it.
    task automatic send_frame(input bit [7:0] data, input int ps, input bit pen, input bit ptyp,
                              input bit pflip, input bit stop_bit, input int gl_bit,
                              input int gl_idx, input int gap);
        ev_t e;
        int  stop_cyc;
        bit  sent_par;
        Prescale = 6'(ps);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        sent_par = (^data) ^ ptyp ^ pflip;
        drive_bit(1'b0, ps, -1);
        for (int i = 0; i < 8; i++)
            drive_bit(data[i], ps, (i == gl_bit) ? gl_idx : -1);
        if (pen)
            drive_bit(sent_par, ps, -1);
        stop_cyc = cyc;
        drive_bit(stop_bit, ps, -1);
        RX_IN = 1'b1;
        repeat (gap) @(posedge CLK);
        if (gap > 0) #1;
        e.pe  = pen && (sent_par != ((^data) ^ ptyp));
        e.se  = !stop_bit;
        e.dv  = !e.pe && !e.se;
        if (e.dv) exp_pdata = data;
        e.d   = exp_pdata;
        e.cyc = stop_cyc + ps / 2 + 6;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string name);
        check_eq($sformatf("%s.count", name), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check_eq($sformatf("%s[%0d].dv", name, i), obs_q[i].dv, exp_q[i].dv);
            check_eq($sformatf("%s[%0d].par_err", name, i), obs_q[i].pe, exp_q[i].pe);
            check_eq($sformatf("%s[%0d].stop_err", name, i), obs_q[i].se, exp_q[i].se);
            check_eq($sformatf("%s[%0d].p_data", name, i), obs_q[i].d, exp_q[i].d);
            check_eq($sformatf("%s[%0d].latency", name, i), obs_q[i].cyc, exp_q[i].cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        check_eq($sformatf("%s.p_data", name), P_DATA, 8'h00);
        check_eq($sformatf("%s.dv", name), Data_Valid, 1'b0);
        check_eq($sformatf("%s.par_err", name), Par_Err, 1'b0);
        check_eq($sformatf("%s.stop_err", name), Stop_Err, 1'b0);
    endtask

    initial begin
        int se_n;
        int dv_n;
        int pe_n;
        RST      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;

        // 1: Prescale 8, no parity, 0xA5.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 16);
        check_events("t1_a5");

        // 2: Prescale 16, even parity, 0x3C with a wrong parity bit.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, 32);
        check_events("t2_bad_par");

        // 3: a 2-clock low pulse is a false start; a following frame proves the receiver is idle.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 2, -1);
        drive_bit(1'b1, 32, -1);
        check_events("t3_glitch_start");
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 16);
        check_events("t3_after");

        // 4: Prescale 32, 0x81 with a bad stop bit, then a good 0x7E.
        send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, 64);
        send_frame(8'h7E, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 64);
        check_events("t4_stop_err");

        // 5: Prescale 16, odd parity, back-to-back frames with a mid-bit glitch in the second.
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, 0);
        send_frame(8'hC3, 16, 1'b1, 1'b1, 1'b0, 1'b1, 2, 9, 32);
        check_events("t5_b2b");

        // 6: reset during data bit 4 aborts the frame; the next frame 0x55 is received.
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        drive_bit(1'b0, 16, -1);
        for (int i = 0; i < 4; i++)
            drive_bit(i[0], 16, -1);
        drive_bit(1'b1, 8, -1);
        RST = 1'b0;
        #1;
        check_reset_outputs("t6_mid_reset");
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        exp_pdata = 8'h00;
        repeat (32) @(posedge CLK);
        #1;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 32);
        check_events("t6_after_reset");

        // Break: line held low repeats stop errors and never yields data.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (300) @(posedge CLK);
        #1;
        se_n = 0;
        dv_n = 0;
        pe_n = 0;
        foreach (obs_q[i]) begin
            se_n += obs_q[i].se;
            dv_n += obs_q[i].dv;
            pe_n += obs_q[i].pe;
        end
        check_eq("break.stop_err_ge3", (se_n >= 3), 1'b1);
        check_eq("break.dv_count", dv_n, 0);
        check_eq("break.par_err_count", pe_n, 0);
        RST   = 1'b0;
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        obs_q.delete();
        exp_q.delete();
        exp_pdata = 8'h00;
        repeat (8) @(posedge CLK);
        #1;

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            int       ps;
            int       gb;
            bit [7:0] d;
            bit       pen, ptyp, pflip, stop_bit;
            case ($urandom_range(0, 2))
                0:       ps = 8;
                1:       ps = 16;
                default: ps = 32;
            endcase
            d        = 8'($urandom);
            pen      = 1'($urandom);
            ptyp     = 1'($urandom);
            pflip    = ($urandom_range(0, 5) == 0);
            stop_bit = ($urandom_range(0, 5) != 0);
            gb       = $urandom_range(0, 9);
            send_frame(d, ps, pen, ptyp, pflip, stop_bit, gb, ps / 2 + $urandom_range(0, 2), 2 * ps);
        end
        check_events("rand");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
